keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 active-low key matrix, debounces one key at a time and emits a single-cycle
//  keyPress pulse with keyType/keyLoc. This is the producing end of the Controller key interface:
//  keyPress/keyType drive Controller directly, and keyLoc is available for memLoc selection.
//  Matrix column = key function (00 clear, 01 set, 10 recall, 11 display).
//  Matrix row = memory location.
// PARAMETERS
//  SCAN_DIV         4    clk cycles each row is driven before its columns are sampled (>=3)
//  DEBOUNCE_CYCLES  8    consecutive stable cycles required for press and for release (>=2)
// PORTS
//  clk       in   1  system clock, rising edge
//  reset_n   in   1  asynchronous active-low reset
//  rowDrive  out  4  matrix row drive, one-hot low; driven row = 0, others = 1
//  colSense  in   4  matrix column inputs, asynchronous, pulled up; 0 = key closed on driven row
//  keyPress  out  1  one-cycle pulse per debounced press
//  keyType   out  2  column index of pressed key; valid in keyPress cycle, held until next press
//  keyLoc    out  2  row index of pressed key; valid in keyPress cycle, held until next press
//  scanBusy  out  1  1 while in DEBOUNCE/PRESS/HOLD/RELEASE (a key is being handled)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=SCAN, row=0, rowDrive=4'b1110.
//    On reset, keyPress=0, keyType=0, keyLoc=0 and scanBusy=0. All counters cleared.
//  - colSense passes through 2-flop synchronizer; all decisions use the synced value colS.
//  - SCAN: dwell counter runs 0..SCAN_DIV-1 on the current row.
//    - At SCAN_DIV-1 with colS==4'hF: row <= row+1, wrapping 3->0; rowDrive follows.
//    - At SCAN_DIV-1 with colS!=4'hF: latch col = lowest index with colS[i]==0, then go to DEBOUNCE.
//      The row is frozen.
//  - DEBOUNCE: count cycles while colS[col]==0.
//    - colS[col]==1 at any cycle: abandon without a pulse; return to SCAN at row+1.
//    - Count reaching DEBOUNCE_CYCLES: go to PRESS.
//  - PRESS (exactly 1 cycle): keyPress=1, keyType=col, keyLoc=row; then go to HOLD.
//  - HOLD: wait for colS==4'hF, then go to RELEASE.
//    A second key pressed on the same row while held is ignored.
//  - RELEASE: count consecutive cycles with colS==4'hF.
//    - Any 0 seen: clear count and return to HOLD.
//    - Count reaching DEBOUNCE_CYCLES: go to SCAN at row+1 with the dwell counter cleared.
//  - Exactly one keyPress per physical press, regardless of hold length. No auto-repeat.
//  - Simultaneous keys: the first row reached in scan order wins; within a row, the lowest column wins.
//  - Press latency from stable closure on the driven row: 2 (sync) + dwell remainder + DEBOUNCE_CYCLES + 1 cycles.
//  - scanBusy=1 exactly when state is not SCAN.
//  - Reset mid-debounce or mid-hold: no pulse is emitted, and scanning restarts at row 0.
//  - Counter widths: $clog2(max(SCAN_DIV,DEBOUNCE_CYCLES)+1); no arithmetic overflow permitted.
// STRUCTURE
//  - keypad_pkg: typedef enum logic [2:0] {SCAN, DEBOUNCE, PRESS, HOLD, RELEASE} kp_state_t.
//    Also: localparam KEY_CLR=2'b00, KEY_SET=2'b01, KEY_RCL=2'b10, KEY_DSP=2'b11; ROWS=4, COLS=4.
//  - Sub-module sync2 #(W=4): 2-flop synchronizer with async active-low reset to all-ones.
//  - Top: one always_ff for state/counters/row, one always_comb for next-state, registered outputs.
// TESTING (bench: SCAN_DIV=4, DEBOUNCE_CYCLES=8; matrix model drives colSense from rowDrive)
//  1. Reset released, no keys pressed.
//     -> rowDrive cycles 1110,1101,1011,0111,1110 every 4 clk; keyPress never asserts; scanBusy=0.
//  2. Key row2/col1 held 100 clk.
//     -> exactly one keyPress pulse with keyType=01, keyLoc=10; scanBusy high until 8 clk after release.
//  3. Key row0/col3 closed for 5 clk, then opened (bounce shorter than debounce).
//     -> no keyPress; scanning resumes at row1.
//  4. Keys row1/col2 and row1/col0 pressed together.
//     -> a single pulse with keyType=00, keyLoc=01; the col2 key does not produce a pulse after col0 is released.
//  5. Key row3/col0 released with 3-clk chatter (0/1 toggling) before a clean open.
//     -> no second pulse; RELEASE count restarts; SCAN resumes at row0 8 clk after last open.
//  6. reset_n pulled low during HOLD of row1/col1.
//     -> outputs are immediately 0 and rowDrive=1110; after release the key still held yields a new
//        pulse with keyType=01, keyLoc=01.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [2:0] {
      SCAN     = 3'd0,
      DEBOUNCE = 3'd1,
      PRESS    = 3'd2,
      HOLD     = 3'd3,
      RELEASE  = 3'd4
   } kp_state_t;

   localparam logic [1:0] KEY_CLR = 2'b00;
   localparam logic [1:0] KEY_SET = 2'b01;
   localparam logic [1:0] KEY_RCL = 2'b10;
   localparam logic [1:0] KEY_DSP = 2'b11;

   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 4;

   // Index of the lowest closed (0) column; 0 when none is closed.
   function automatic logic [1:0] lowest_zero(input logic [COLS-1:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (!v[i]) r = 2'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer; resets to all-ones so an idle (pulled-up) bus reads open.
module sync2 #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix scanner: one key debounced at a time, single-cycle keyPress pulse.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic [3:0] rowDrive,
   input  logic [3:0] colSense,
   output logic       keyPress,
   output logic [1:0] keyType,
   output logic [1:0] keyLoc,
   output logic       scanBusy
);

   localparam int unsigned MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0] colS;

   kp_state_t     state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    row, row_n;
   logic [1:0]    col, col_n;
   logic          press_n;
   logic [1:0]    type_n, loc_n;

   sync2 #(.W(COLS)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (colSense),
      .q       (colS)
   );

   // Next-state, counter, row and output decode.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      row_n   = row;
      col_n   = col;
      press_n = 1'b0;
      type_n  = keyType;
      loc_n   = keyLoc;
      case (state)
         SCAN: begin
            if (cnt == DWELL_LAST) begin
               cnt_n = '0;
               if (colS == 4'hF) begin
                  row_n = row + 2'd1;
               end else begin
                  col_n   = lowest_zero(colS);
                  state_n = DEBOUNCE;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DEBOUNCE: begin
            if (colS[col]) begin
               state_n = SCAN;
               row_n   = row + 2'd1;
               cnt_n   = '0;
            end else if (cnt == DEB_LAST) begin
               state_n = PRESS;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         PRESS: begin
            press_n = 1'b1;
            type_n  = col;
            loc_n   = row;
            state_n = HOLD;
            cnt_n   = '0;
         end
         HOLD: begin
            // The first all-open cycle already counts toward release.
            if (colS == 4'hF) begin
               state_n = RELEASE;
               cnt_n   = CW'(1);
            end
         end
         RELEASE: begin
            if (colS != 4'hF) begin
               state_n = HOLD;
               cnt_n   = '0;
            end else if (cnt == DEB_LAST) begin
               state_n = SCAN;
               row_n   = row + 2'd1;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = SCAN;
            row_n   = 2'd0;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= SCAN;
         cnt      <= '0;
         row      <= 2'd0;
         col      <= 2'd0;
         rowDrive <= 4'b1110;
         keyPress <= 1'b0;
         keyType  <= 2'd0;
         keyLoc   <= 2'd0;
         scanBusy <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         row      <= row_n;
         col      <= col_n;
         rowDrive <= ~(4'b0001 << row_n);
         keyPress <= press_n;
         keyType  <= type_n;
         keyLoc   <= loc_n;
         scanBusy <= (state_n != SCAN);
      end
   end

endmodule
